// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel enable in, position and sync flags out.
// The master drives the timing; the slave consumes it.
interface video_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output h_cnt,
    output v_cnt,
    output de,
    output hsync,
    output vsync,
    output line_start,
    output frame_start
  );

  modport slave (
    output en,
    input  h_cnt,
    input  v_cnt,
    input  de,
    input  hsync,
    input  vsync,
    input  line_start,
    input  frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Registered raster timing source for the Sobel pipeline.
// Every output carries the decode of the position it reports.
module video_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_PW      = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_PW      = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 11
) (
  input  logic clk,
  input  logic rst,
  video_timing_gen_if.master vt
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FP + H_PW + H_BP;
  localparam int V_TOTAL =
    V_VISIBLE + V_FP + V_PW + V_BP;

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS =
    CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS =
    CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_VISIBLE + H_FP + H_PW);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_VISIBLE + V_FP + V_PW);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [CNT_W-1:0] hc_nxt;
  logic [CNT_W-1:0] vc_nxt;

  logic de_d;
  logic hs_act;
  logic vs_act;
  logic ls_d;
  logic fs_d;

  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic             de_q;
  logic             hs_q;
  logic             vs_q;
  logic             ls_q;
  logic             fs_q;

  always_comb begin
    hc_nxt = hc + 1'b1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      if (vc == V_LAST) begin
        vc_nxt = '0;
      end else begin
        vc_nxt = vc + 1'b1;
      end
    end
  end

  // Decode of the position about to be presented.
  always_comb begin
    de_d   = (hc < H_VIS) && (vc < V_VIS);
    hs_act = (hc >= HS_BEG) && (hc < HS_END);
    vs_act = (vc >= VS_BEG) && (vc < VS_END);
    ls_d   = (hc == HS_BEG);
    fs_d   = (hc == '0) && (vc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (vt.en) begin
      hc <= hc_nxt;
      vc <= vc_nxt;
    end
  end

  // Pulses drop on idle edges so each lasts one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (vt.en) begin
      h_q  <= hc;
      v_q  <= vc;
      de_q <= de_d;
      hs_q <= hs_act ? HS_POL : ~HS_POL;
      vs_q <= vs_act ? VS_POL : ~VS_POL;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end
  end

  assign vt.h_cnt       = h_q;
  assign vt.v_cnt       = v_q;
  assign vt.de          = de_q;
  assign vt.hsync       = hs_q;
  assign vt.vsync       = vs_q;
  assign vt.line_start  = ls_q;
  assign vt.frame_start = fs_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator at the head of the Sobel video pipeline. It counts pixel positions over a full frame (visible area plus blanking) and produces de, hsync and vsync. It also produces a line_start pulse that resets the line_delay stages and a frame_start pulse for downstream frame logic. It replaces ad-hoc bench counters with one synthesizable, registered source of timing.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (cycles)
H_PW, 96, hsync pulse width (cycles, >=1)
H_BP, 48, horizontal back porch (cycles)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_PW, 2, vsync pulse width (lines, >=1)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
en  in  1  pixel clock enable; counters advance only when 1
h_cnt  out  CNT_W  horizontal position of the current output pixel
v_cnt  out  CNT_W  vertical position of the current output pixel
de  out  1  data enable; high in the visible area
hsync  out  1  horizontal sync at HS_POL level when active
vsync  out  1  vertical sync at VS_POL level when active
line_start  out  1  one-cycle pulse at the first hsync-active position of each line
frame_start  out  1  one-cycle pulse at position (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_PW+H_BP; V_TOTAL = V_VISIBLE+V_FP+V_PW+V_BP.
- Internal counters hc and vc. On each clk edge with en=1, hc increments. At H_TOTAL-1, hc wraps to 0 and vc increments. When vc is at V_TOTAL-1 and hc wraps, vc also wraps to 0.
- Decode for position (hc,vc):
  - de = hc<H_VISIBLE && vc<V_VISIBLE.
  - hsync active when H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_PW (exactly H_PW cycles).
  - vsync active when V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_PW (exactly V_PW lines), for the whole of each such line.
  - line_start when hc == H_VISIBLE+H_FP, on every line including vertical blanking.
  - frame_start when hc==0 && vc==0.
- All outputs are registered and mutually aligned. On an en=1 edge, h_cnt/v_cnt load (hc,vc) and every flag loads its decode of that same position. Then hc,vc advance.
- Reset (rst=1 at an edge) has priority over en:
  - hc=vc=0.
  - h_cnt=v_cnt=0, de=0, line_start=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL.
- First en=1 edge after reset release outputs (0,0) with de=1 and frame_start=1. Latency from that edge to the first visible output is 0 cycles.
- en=0 edge:
  - hc, vc, h_cnt, v_cnt, de, hsync and vsync hold.
  - line_start and frame_start are forced to 0, so each pulse lasts exactly one clk cycle per position.
- Reset mid-frame restarts at (0,0) on the next en=1 edge. No partial-frame completion.
- Widths: comparisons use CNT_W-bit unsigned values; no truncation for legal parameters.

Test Plan:
- Params H 12/2/1/5 (H_TOTAL=20), V 5/1/1/2 (V_TOTAL=9), en=1. Release rst → first output h_cnt=0, v_cnt=0, de=1, frame_start=1. de is high 12 cycles per line for lines 0–4 and never high on lines 5–8.
- Same params → hsync low (HS_POL=0) for exactly 1 cycle at h_cnt=14 on every line. line_start pulses at h_cnt=14. Period is 20 cycles.
- Same params → vsync active for all 20 cycles of v_cnt=6 only. frame_start pulses every 180 cycles, only at (0,0). v_cnt wraps 8→0.
- en toggling 1,0,1,0… → counters advance once per two clocks. Held values are stable while en=0. line_start/frame_start are never high for 2 consecutive clocks.
- Assert rst for 1 cycle at (h_cnt=7, v_cnt=3) → next output is the reset state. The following en=1 edge outputs (0,0) with frame_start=1.
- HS_POL=1, VS_POL=1 → hsync/vsync idle low and pulse high at the same positions as above. Reset drives both low.
